// File: rtl/power_clock_manager.sv
// Clock manager: measures silicon speed (PSI) and external oscillator frequency (Fro),
// and generates Main_Clock as clk_50MHz divided by a closed-loop-controlled divisor.
`timescale 1ns/100ps
module power_clock_manager #(
    parameter int RO_PERIODS = 12,
    parameter int FRO_WINDOW = 50,
    parameter int DIV_MAX    = 8
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       internal_ro,
    input  logic       external_ro,
    input  logic [7:0] Fro_min,
    input  logic [7:0] PSI_min,
    input  logic [7:0] PSI_max,
    input  logic [7:0] PSI_set,
    input  logic       Power_Mode,
    output logic       Main_Clock
);

    localparam int DW = $clog2(DIV_MAX + 1);
    localparam int EW = $clog2(RO_PERIODS + 1);
    localparam int WW = $clog2(FRO_WINDOW);

    // Bit 0 = internal_ro, bit 1 = external_ro
    logic [1:0] w_ro_in;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_sync3;
    logic [1:0] w_rise;

    assign w_ro_in = {external_ro, internal_ro};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ro_sync
            always_ff @(posedge clk_50MHz or negedge rst) begin
                if (!rst) begin
                    r_sync1[gi] <= 1'b0;
                    r_sync2[gi] <= 1'b0;
                    r_sync3[gi] <= 1'b0;
                end else begin
                    r_sync1[gi] <= w_ro_in[gi];
                    r_sync2[gi] <= r_sync1[gi];
                    r_sync3[gi] <= r_sync2[gi];
                end
            end
            assign w_rise[gi] = r_sync2[gi] & ~r_sync3[gi];
        end
    endgenerate

    logic          r_psi_run;
    logic [7:0]    r_psi_cnt;
    logic [EW-1:0] r_psi_edges;
    logic [7:0]    r_psi;
    logic          r_psi_valid;
    logic          r_psi_update;
    logic [7:0]    w_psi_cnt_inc;

    assign w_psi_cnt_inc = (r_psi_cnt == 8'hFF) ? 8'hFF : r_psi_cnt + 8'd1;

    // The closing edge of one window is the opening edge of the next
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_psi_run    <= 1'b0;
            r_psi_cnt    <= 8'd0;
            r_psi_edges  <= '0;
            r_psi        <= 8'd0;
            r_psi_valid  <= 1'b0;
            r_psi_update <= 1'b0;
        end else begin
            r_psi_update <= 1'b0;
            if (w_rise[0]) begin
                if (!r_psi_run) begin
                    r_psi_run   <= 1'b1;
                    r_psi_cnt   <= 8'd0;
                    r_psi_edges <= '0;
                end else if (r_psi_edges == EW'(RO_PERIODS - 1)) begin
                    r_psi        <= w_psi_cnt_inc;
                    r_psi_valid  <= 1'b1;
                    r_psi_update <= 1'b1;
                    r_psi_cnt    <= 8'd0;
                    r_psi_edges  <= '0;
                end else begin
                    r_psi_edges <= r_psi_edges + EW'(1);
                    r_psi_cnt   <= w_psi_cnt_inc;
                end
            end else if (r_psi_run) begin
                r_psi_cnt <= w_psi_cnt_inc;
            end
        end
    end

    logic [WW-1:0] r_win;
    logic [7:0]    r_fro_cnt;
    logic [7:0]    r_fro;
    logic          r_fro_valid;
    logic [7:0]    w_fro_inc;

    assign w_fro_inc = (w_rise[1] && r_fro_cnt != 8'hFF) ? r_fro_cnt + 8'd1 : r_fro_cnt;

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_win       <= '0;
            r_fro_cnt   <= 8'd0;
            r_fro       <= 8'd0;
            r_fro_valid <= 1'b0;
        end else if (r_win == WW'(FRO_WINDOW - 1)) begin
            r_fro       <= w_fro_inc;
            r_fro_valid <= 1'b1;
            r_fro_cnt   <= 8'd0;
            r_win       <= '0;
        end else begin
            r_fro_cnt <= w_fro_inc;
            r_win     <= r_win + WW'(1);
        end
    end

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_next;
    logic          w_eval;

    assign w_eval = r_psi_update & r_psi_valid & r_fro_valid;

    always_comb begin
        w_div_next = r_div;
        if (r_fro < Fro_min) begin
            w_div_next = DW'(DIV_MAX);
        end else if (Power_Mode) begin
            w_div_next = (r_div == DW'(DIV_MAX)) ? r_div : r_div + DW'(1);
        end else if (r_psi > PSI_min) begin
            w_div_next = DW'(DIV_MAX);
        end else if (r_psi < PSI_max) begin
            w_div_next = DW'(1);
        end else if (r_psi > PSI_set) begin
            w_div_next = (r_div == DW'(DIV_MAX)) ? r_div : r_div + DW'(1);
        end else if (r_psi < PSI_set) begin
            w_div_next = (r_div == DW'(1)) ? r_div : r_div - DW'(1);
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_div <= DW'(DIV_MAX);
        end else if (w_eval) begin
            r_div <= w_div_next;
        end
    end

    logic [DW-1:0] r_ph_cnt;
    logic [DW-1:0] r_active_div;
    logic          r_main_clk;

    // Divisor is only adopted at a toggle so no phase is ever cut short
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_ph_cnt     <= '0;
            r_active_div <= DW'(DIV_MAX);
            r_main_clk   <= 1'b0;
        end else if (r_ph_cnt == r_active_div - DW'(1)) begin
            r_ph_cnt     <= '0;
            r_active_div <= r_div;
            r_main_clk   <= ~r_main_clk;
        end else begin
            r_ph_cnt <= r_ph_cnt + DW'(1);
        end
    end

    assign Main_Clock = r_main_clk;

endmodule

// File: tb/tb_power_clock_manager.sv
// Self-checking bench: observes Main_Clock phase lengths and compares divisor behaviour
// against an abstract model of the PSI/Fro driven divisor policy.
`timescale 1ns/100ps
module tb_power_clock_manager;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iro = 1'b0;
    logic       ero = 1'b0;
    logic [7:0] fro_min = 8'd20;
    logic [7:0] psi_min = 8'd160;
    logic [7:0] psi_max = 8'd90;
    logic [7:0] psi_set = 8'd125;
    logic       mode = 1'b0;
    logic       main_clk;

    int checks = 0;
    int errors = 0;
    real iro_half = 0.0;
    real ero_half = 0.0;
    int phases[$];
    int psi_exp = 0;
    int fro_exp = 24;

    power_clock_manager dut (
        .clk_50MHz  (clk),
        .rst        (rst_n),
        .internal_ro(iro),
        .external_ro(ero),
        .Fro_min    (fro_min),
        .PSI_min    (psi_min),
        .PSI_max    (psi_max),
        .PSI_set    (psi_set),
        .Power_Mode (mode),
        .Main_Clock (main_clk)
    );

    always #10 clk = ~clk;

    // Internal oscillator edges stay 3 ns off the clock grid so PSI is exact
    initial begin
        #3;
        forever begin
            if (iro_half == 0.0) begin
                iro = 1'b0;
                #20;
            end else begin
                #(iro_half) iro = ~iro;
            end
        end
    end

    initial begin
        #7;
        forever begin
            if (ero_half == 0.0) begin
                ero = 1'b0;
                #20;
            end else begin
                #(ero_half) ero = ~ero;
            end
        end
    end

    function automatic int model_next(input int d);
        if (fro_exp < int'(fro_min)) return 8;
        if (mode) return (d < 8) ? d + 1 : 8;
        if (psi_exp > int'(psi_min)) return 8;
        if (psi_exp < int'(psi_max)) return 1;
        if (psi_exp > int'(psi_set)) return (d < 8) ? d + 1 : 8;
        if (psi_exp < int'(psi_set)) return (d > 1) ? d - 1 : 1;
        return d;
    endfunction

    function automatic int model_fixed(input int d);
        int x = d;
        for (int i = 0; i < 20; i++) x = model_next(x);
        return x;
    endfunction

    task automatic set_iro_period_cycles(input int m);
        iro_half = 10.0 * m;
        psi_exp  = 12 * m;
    endtask

    // Collect complete Main_Clock phase lengths (in clk cycles) over a bounded window
    task automatic record(input int ncyc);
        int   run = 0;
        bit   started = 0;
        logic prev;
        phases.delete();
        @(negedge clk);
        prev = main_clk;
        repeat (ncyc) begin
            @(negedge clk);
            run++;
            if (main_clk !== prev) begin
                if (started) phases.push_back(run);
                started = 1;
                run = 0;
                prev = main_clk;
            end
        end
    endtask

    task automatic check_seq(input string name, input int final_exp, input int min_len);
        int seq[$];
        int bad = 0;
        foreach (phases[i]) begin
            if (seq.size() == 0 || seq[seq.size()-1] != phases[i]) seq.push_back(phases[i]);
        end
        checks++;
        if (seq.size() < min_len) begin
            errors++;
            $display("FAIL %s_len distinct_divisors=%0d required_at_least=%0d", name, seq.size(), min_len);
        end
        for (int i = 1; i < seq.size(); i++) begin
            if (seq[i] != model_next(seq[i-1])) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_steps illegal_divisor_steps=%0d required=0 (seq size %0d)", name, bad, seq.size());
        end
        checks++;
        if (seq.size() == 0) begin
            errors++;
            $display("FAIL %s_final no_phases_seen required_div=%0d", name, final_exp);
        end else if (seq[seq.size()-1] != final_exp) begin
            errors++;
            $display("FAIL %s_final div=%0d required=%0d", name, seq[seq.size()-1], final_exp);
        end
        $display("%s: phases=%0d distinct=%0d final_req=%0d", name, phases.size(), seq.size(), final_exp);
    endtask

    task automatic check_all_equal(input string name, input int req);
        int bad = 0;
        foreach (phases[i]) if (phases[i] != req) bad++;
        checks++;
        if (bad != 0 || phases.size() < 10) begin
            errors++;
            $display("FAIL %s phases_off=%0d count=%0d required_phase=%0d", name, bad, phases.size(), req);
        end
        $display("%s: phases=%0d all required %0d", name, phases.size(), req);
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (main_clk !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_hold main_clk_high_samples=%0d required=0", bad);
        end
        @(negedge clk);
        rst_n = 1'b1;
        record(400);
        check_all_equal("reset_release_div8", 8);
    endtask

    task automatic test_perf_ramp();
        mode = 1'b0;
        fro_min = 8'd20; psi_min = 8'd160; psi_max = 8'd90; psi_set = 8'd125;
        ero_half = 20.8;
        set_iro_period_cycles(10);
        record(1700);
        check_seq("perf_ramp", model_fixed(8), 8);
    endtask

    task automatic test_low_power();
        mode = 1'b1;
        record(1200);
        check_seq("low_power", model_fixed(1), 7);
    endtask

    task automatic test_fro_fault();
        mode = 1'b0;
        fro_min = 8'd20;
        repeat (1200) @(negedge clk);
        record(100);
        check_seq("fro_ok_ramp_down", model_fixed(8), 1);
        fro_min = 8'd30;
        record(300);
        check_seq("fro_fault", model_fixed(1), 1);
    endtask

    task automatic test_corners();
        set_iro_period_cycles(5);
        repeat (300) @(negedge clk);
        fro_min = 8'd20;
        record(300);
        check_seq("corner_fast", model_fixed(8), 2);
        psi_min = 8'd255; psi_max = 8'd255;
        repeat (200) @(negedge clk);
        set_iro_period_cycles(20);
        repeat (600) @(negedge clk);
        psi_min = 8'd160; psi_max = 8'd90;
        record(600);
        check_seq("corner_slow", model_fixed(1), 2);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int m = $urandom_range(5, 20);
            int req;
            set_iro_period_cycles(m);
            mode    = 1'($urandom_range(0, 1));
            fro_min = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(30, 255)) : 8'($urandom_range(0, 20));
            psi_min = 8'($urandom_range(0, 255));
            psi_max = 8'($urandom_range(0, 255));
            psi_set = 8'($urandom_range(0, 255));
            if (int'(psi_set) == psi_exp) psi_set = psi_set + 8'd1;
            req = model_fixed(1);
            repeat (12 * m * 12) @(negedge clk);
            record(60);
            check_all_equal_short(t, req);
        end
    endtask

    task automatic check_all_equal_short(input int t, input int req);
        int bad = 0;
        foreach (phases[i]) if (phases[i] != req) bad++;
        checks++;
        if (bad != 0 || phases.size() < 2) begin
            errors++;
            $display("FAIL random_%0d phases_off=%0d count=%0d required_div=%0d psi=%0d mode=%0d", t, bad, phases.size(), req, psi_exp, mode);
        end
        $display("random_%0d: psi=%0d fro_min=%0d mode=%0d required_div=%0d phases=%0d", t, psi_exp, fro_min, mode, req, phases.size());
    endtask

    task automatic test_stopped_and_async_reset();
        int waited = 0;
        mode = 1'b0; fro_min = 8'd0; psi_min = 8'd255; psi_max = 8'd255;
        set_iro_period_cycles(5);
        repeat (400) @(negedge clk);
        iro_half = 0.0;
        repeat (100) @(negedge clk);
        record(300);
        check_all_equal("osc_stopped_holds_div1", 1);
        @(negedge clk);
        while (main_clk !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (main_clk !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_setup main_clk=%b required=1 within 20 cycles", main_clk);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (main_clk !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate main_clk=%b required=0", main_clk);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        record(400);
        check_all_equal("after_async_reset_div8", 8);
    endtask

    initial begin
        test_reset();
        test_perf_ramp();
        test_low_power();
        test_fro_fault();
        test_corners();
        test_random();
        test_stopped_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
